// File: rtl/frame_seq_pkg.sv
// Shared types and defaults for the frame sequencer.
//   state_e          : sequencer FSM state encoding
//   STATE_W          : width of the state encoding
//   FRAME_CYCLES_DEF : default frame period in clocks (60 Hz at 50 MHz)
package frame_seq_pkg;

  localparam int unsigned FRAME_CYCLES_DEF = 833333;
  localparam int          STATE_W          = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_CLEAR,
    S_CLEAR_WAIT,
    S_DRAW,
    S_DRAW_WAIT,
    S_HOLD,
    S_ERASE,
    S_ERASE_WAIT,
    S_ADVANCE
  } state_e;

endpackage

// File: rtl/frame_sequencer_timer.sv
// frame_timer: restartable saturating cycle counter that marks the end of
// a frame period.
//   clock   in  : system clock
//   reset   in  : asynchronous active-high reset
//   restart in  : the cycle in which this is high counts as cycle 0
//   done    out : high once FRAME_CYCLES-1 cycles have elapsed since the
//                 restart cycle; held until the next restart
module frame_timer
  import frame_seq_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int          CNT_W        = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    // The restart cycle itself is count 0, so the following cycle reads 1.
    if (restart)              count_d = CNT_W'(1);
    else if (count_q != LAST) count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done = (count_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame animation controller. Clears the screen once,
// then repeats draw -> hold for the frame period -> erase -> advance angle.
// Optional macro FRAME_SEQ_SINGLE_STEP_EN adds a 'step' input that runs
// exactly one frame from IDLE while run is low.
//   clock, reset            : clock and asynchronous active-high reset
//   run                     : level; frames repeat while high
//   clear_start/clear_done  : clear-engine handshake (one-cycle pulses)
//   draw_start/draw_done    : draw-engine handshake (one-cycle pulses)
//   draw_erase              : 1 = current draw uses the background colour
//   angle                   : rotation angle for the transform
//   frame_tick              : one-cycle pulse at the end of each frame
//   busy                    : high in every state except IDLE
//   overrun                 : sticky; a draw outlasted the frame period
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int          CNT_W        = 20,
  parameter int          ANGLE_W      = 8,
  parameter int unsigned ANGLE_STEP   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
`ifdef FRAME_SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               clear_start,
  input  logic               clear_done,
  output logic               draw_start,
  output logic               draw_erase,
  input  logic               draw_done,
  output logic [ANGLE_W-1:0] angle,
  output logic               frame_tick,
  output logic               busy,
  output logic               overrun
);

  state_e             state_q;
  logic               first_frame_q;
  logic               single_q;
  logic               clear_start_q, draw_start_q, draw_erase_q;
  logic               frame_tick_q, busy_q, overrun_q;
  logic [ANGLE_W-1:0] angle_q;
  logic               timer_done;
  logic               go, go_single;

`ifdef FRAME_SEQ_SINGLE_STEP_EN
  assign go        = run | step;
  assign go_single = ~run & step;
`else
  assign go        = run;
  assign go_single = 1'b0;
`endif

  frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .restart (state_q == S_DRAW),
    .done    (timer_done)
  );

  // Outputs are registered: each pulse is raised on the edge that enters
  // the state it belongs to, so it is high for exactly that state's cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      first_frame_q <= 1'b1;
      single_q      <= 1'b0;
      clear_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      draw_erase_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      angle_q       <= '0;
    end else begin
      clear_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (go) begin
          single_q <= go_single;
          busy_q   <= 1'b1;
          if (first_frame_q) begin
            state_q       <= S_CLEAR;
            clear_start_q <= 1'b1;
          end else begin
            state_q      <= S_DRAW;
            draw_start_q <= 1'b1;
            draw_erase_q <= 1'b0;
          end
        end
        S_CLEAR: state_q <= S_CLEAR_WAIT;
        S_CLEAR_WAIT: if (clear_done) begin
          first_frame_q <= 1'b0;
          state_q       <= S_DRAW;
          draw_start_q  <= 1'b1;
          draw_erase_q  <= 1'b0;
        end
        S_DRAW: state_q <= S_DRAW_WAIT;
        S_DRAW_WAIT: if (draw_done) begin
          // Period already used up: flag it; HOLD then lasts one cycle.
          if (timer_done) overrun_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: if (timer_done) begin
          state_q      <= S_ERASE;
          draw_start_q <= 1'b1;
          draw_erase_q <= 1'b1;
        end
        S_ERASE: state_q <= S_ERASE_WAIT;
        S_ERASE_WAIT: if (draw_done) begin
          state_q      <= S_ADVANCE;
          frame_tick_q <= 1'b1;
          draw_erase_q <= 1'b0;
        end
        S_ADVANCE: begin
          angle_q <= angle_q + ANGLE_W'(ANGLE_STEP);
          if (run && !single_q) begin
            state_q      <= S_DRAW;
            draw_start_q <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            single_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clear_start = clear_start_q;
  assign draw_start  = draw_start_q;
  assign draw_erase  = draw_erase_q;
  assign frame_tick  = frame_tick_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign angle       = angle_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  localparam int FC      = 20;
  localparam int ANGLE_W = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               run = 1'b0;
  logic               step = 1'b0;
  logic               clear_done = 1'b0;
  logic               draw_done = 1'b0;
  logic               clear_start, draw_start, draw_erase;
  logic               frame_tick, busy, overrun;
  logic [ANGLE_W-1:0] angle;

  int checks = 0;
  int errors = 0;
  int nc = 0;      // posedges seen; at a negedge equals the current cycle
  int ang_m = 0;   // reference angle
  bit ovr_m = 0;   // reference sticky overrun

  typedef struct {
    int ld;        // draw_done latency after draw_start (cycles)
    int le;        // erase done latency
    int exp_off;   // erase draw_start cycle minus draw draw_start cycle
    bit exp_ovr;   // overrun after this frame
  } vec_t;
  vec_t tbl[5];

  frame_sequencer #(
    .FRAME_CYCLES (FC),
    .CNT_W        (8),
    .ANGLE_W      (ANGLE_W),
    .ANGLE_STEP   (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
`ifdef FRAME_SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .clear_start (clear_start),
    .clear_done  (clear_done),
    .draw_start  (draw_start),
    .draw_erase  (draw_erase),
    .draw_done   (draw_done),
    .angle       (angle),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) nc <= nc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, nc);
    end
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return clear_start;
      1:       return draw_start;
      default: return frame_tick;
    endcase
  endfunction

  // Looks at the current negedge first, then up to 'budget' more.
  task automatic wait_for(input string nm, input int sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i <= budget; i++) begin
      if (i > 0) @(negedge clock);
      if (sel_sig(sel) === 1'b1) begin
        at = nc;
        return;
      end
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  // One complete frame from the draw pulse through ADVANCE.
  task automatic do_frame(input int ld, input int le, input int exp_off,
                          input bit exp_ovr, input bit drop_run);
    int t, e;
    wait_for("draw_start", 1, 60, t);
    check("draw_erase_lo", draw_erase, 0);
    repeat (ld) begin
      @(negedge clock);
      if (drop_run) run = 1'b0;
    end
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    wait_for("erase_start", 1, 60, e);
    check("erase_offset", e - t, exp_off);
    check("draw_erase_hi", draw_erase, 1);
    check("overrun", overrun, exp_ovr);
    repeat (le) @(negedge clock);
    check("erase_held", draw_erase, 1);
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    check("frame_tick", frame_tick, 1);
    ang_m = (ang_m + 1) % (1 << ANGLE_W);
    @(negedge clock);
    check("frame_tick_pulse", frame_tick, 0);
    check("angle", angle, ang_m);
    if (drop_run) begin
      check("idle_busy", busy, 0);
      check("idle_no_draw", draw_start, 0);
    end
  endtask

  initial begin
    int c, t, spur, ld, le, off;

    tbl[0] = '{ld: 5,  le: 3, exp_off: 20, exp_ovr: 0};
    tbl[1] = '{ld: 1,  le: 1, exp_off: 20, exp_ovr: 0};
    tbl[2] = '{ld: 18, le: 2, exp_off: 20, exp_ovr: 0};
    tbl[3] = '{ld: 19, le: 1, exp_off: 21, exp_ovr: 1};
    tbl[4] = '{ld: 30, le: 4, exp_off: 32, exp_ovr: 1};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_outs", {busy, clear_start, draw_start, draw_erase, frame_tick, overrun, angle}, 0);
    reset = 1'b0;
    run   = 1'b1;

    // First frame: clear, with stray done pulses that must be ignored
    wait_for("clear_start", 0, 10, c);
    check("busy_on", busy, 1);
    clear_done = 1'b1;                 // same cycle as clear_start
    @(negedge clock);
    clear_done = 1'b0;
    check("clear_single", clear_start, 0);
    draw_done = 1'b1;                  // wrong handshake in CLEAR_WAIT
    @(negedge clock);
    draw_done = 1'b0;
    check("no_early_draw", draw_start, 0);
    @(negedge clock);
    clear_done = 1'b1;                 // 3 cycles after clear_start
    @(negedge clock);
    clear_done = 1'b0;
    check("draw_after_clear", draw_start, 1);
    check("draw_cycle", nc - c, 4);

    // Table-driven frames
    foreach (tbl[i]) begin
      if (tbl[i].ld >= FC - 1) ovr_m = 1;
      do_frame(tbl[i].ld, tbl[i].le, tbl[i].exp_off, tbl[i].exp_ovr, 1'b0);
    end

    // run dropped in DRAW_WAIT: frame finishes, then stays idle
    do_frame(6, 2, FC, ovr_m, 1'b1);
    spur = 0;
    repeat (10) begin
      @(negedge clock);
      spur += int'(draw_start) + int'(clear_start) + int'(busy);
    end
    check("idle_quiet", spur, 0);
    run = 1'b1;
    @(negedge clock);
    check("run_latency", draw_start, 1);
    check("no_second_clear", clear_start, 0);

    // Randomised frames against the reference model (passes the angle wrap)
    for (int n = 0; n < 260; n++) begin
      ld  = $urandom_range(25, 1);
      le  = $urandom_range(5, 1);
      off = (ld + 2 > FC) ? ld + 2 : FC;
      if (ld >= FC - 1) ovr_m = 1;
      do_frame(ld, le, off, ovr_m, 1'b0);
    end

    // Asynchronous reset while in HOLD
    wait_for("draw_start", 1, 60, t);
    repeat (2) @(negedge clock);
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    @(negedge clock);
    check("in_hold_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check("async_reset_outs",
             {busy, clear_start, draw_start, draw_erase, frame_tick, overrun, angle}, 0);
    ang_m = 0;
    ovr_m = 0;
    @(negedge clock);
    reset = 1'b0;
    wait_for("clear_again", 0, 10, c);
    check("clear_again_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
